// File: rtl/poly_stream_sink.sv
// poly_stream_sink: receiving end of the z coefficient stream from the
// polynomial multiplier. It captures one frame of N coefficients into a
// local buffer and checks the framing against z_last. It flags framing
// errors and overruns. A registered random-access read port serves the
// captured frame until the buffer is released.
//
// Handshake: a beat transfers on a rising edge where z_vld and z_rdy are
// both high. z_rdy does not depend on z_vld. Upstream may not withdraw a
// beat, and it treats the interface as always ready, so any z_vld seen
// while z_rdy is low is recorded as an overrun and the beat is dropped.
//
// Buffer release input: buf_release.
module poly_stream_sink #(
    parameter int N  = 16,
    parameter int QW = 64,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          s_rst,
    input  logic          z_vld,
    output logic          z_rdy,
    input  logic [QW-1:0] z,
    input  logic          z_last,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [QW-1:0] rd_data,
    output logic          rd_vld,
    input  logic          buf_release,
    output logic          full,
    output logic [AW:0]   frame_len,
    output logic          err_last,
    output logic          err_ovf
);

    localparam logic [0:0] ST_RECV = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] wr_idx;
    logic [QW-1:0] mem [N];

    logic accept;
    logic at_end;
    logic in_range;

    // Ready only while collecting a frame, and never during reset.
    assign z_rdy    = (state == ST_RECV) && !s_rst;
    assign full     = (state == ST_FULL);
    assign accept   = z_vld && z_rdy;
    assign at_end   = (wr_idx == AW'(N - 1));
    // Addresses beyond the captured frame read as zero.
    assign in_range = ({1'b0, rd_addr} < frame_len);

    // Buffer write port: no reset, because contents are only read after a write.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_idx] <= z;
        end
    end

    // Frame FSM, framing/overrun flags and the registered read port.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state     <= ST_RECV;
            wr_idx    <= '0;
            frame_len <= '0;
            rd_vld    <= 1'b0;
            rd_data   <= '0;
            err_last  <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            rd_vld <= 1'b0;
            case (state)
                ST_RECV: begin
                    if (accept) begin
                        wr_idx <= wr_idx + AW'(1);
                        if (at_end) begin
                            // Buffer filled. A missing z_last means the
                            // upstream frame is longer than N.
                            frame_len <= (AW+1)'(N);
                            state     <= ST_FULL;
                            if (!z_last) begin
                                err_last <= 1'b1;
                            end
                        end else if (z_last) begin
                            // The frame was terminated before N coefficients.
                            err_last  <= 1'b1;
                            frame_len <= {1'b0, wr_idx} + (AW+1)'(1);
                            state     <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (z_vld) begin
                        err_ovf <= 1'b1;
                    end
                    if (rd_en) begin
                        rd_vld  <= 1'b1;
                        rd_data <= in_range ? mem[rd_addr] : '0;
                    end
                    // A read issued together with the release still sees the
                    // old data, because no write can land before this edge.
                    if (buf_release) begin
                        state  <= ST_RECV;
                        wr_idx <= '0;
                    end
                end
                default: begin
                    state <= ST_RECV;
                end
            endcase
        end
    end

endmodule
